m_axi_wr_master: RTL and testbench

AXI write-channel initiator that drives the AW/W/B channels of a write responder such as our `s_axi_reg` register slave. It accepts single-beat write commands on a simple valid/ready command port and issues one AXI write per command. It collects the write response and reports completion, the response code, and a response timeout to the local logic.

---
 rtl/m_axi_wr_master.sv | 131 +++++++++++++
 tb/tb_m_axi_wr_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi_wr_master.sv
// Single-beat AXI write initiator: one command in, one AW/W pair out, B collected
// with a bounded wait; completion is reported as a one-cycle done pulse.
module m_axi_wr_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [ID_W-1:0]     cmd_id_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_data_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic [ID_W-1:0]     awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [ID_W-1:0]     bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic                done_o,
  output logic [1:0]          done_resp_o,
  output logic                done_timeout_o
);

  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_TMO    = 2'b11;
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

  state_t      state;
  logic        aw_done, w_done;
  logic [15:0] b_cnt;
  logic        aw_hs, w_hs, b_hs;

  assign aw_hs = awvalid_o && awready_i;
  assign w_hs  = wvalid_o && wready_i;
  assign b_hs  = bvalid_i && bready_o;

  // Every output is a register; valids are set/cleared only from state, never from ready.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state          <= IDLE;
      cmd_ready_o    <= 1'b0;
      awid_o         <= '0;
      awaddr_o       <= '0;
      awvalid_o      <= 1'b0;
      wdata_o        <= '0;
      wstrb_o        <= '0;
      wvalid_o       <= 1'b0;
      bready_o       <= 1'b0;
      done_o         <= 1'b0;
      done_resp_o    <= 2'b00;
      done_timeout_o <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      b_cnt          <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            awid_o      <= cmd_id_i;
            awaddr_o    <= cmd_addr_i;
            wdata_o     <= cmd_data_i;
            wstrb_o     <= cmd_strb_i;
            awvalid_o   <= 1'b1;
            wvalid_o    <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready_o <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (aw_hs) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          // Channels finish independently; include this cycle's handshakes.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_o <= 1'b1;
            b_cnt    <= '0;
            state    <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (b_hs) begin
            bready_o       <= 1'b0;
            done_o         <= 1'b1;
            done_resp_o    <= (bid_i == awid_o) ? bresp_i : RESP_SLVERR;
            done_timeout_o <= 1'b0;
            cmd_ready_o    <= 1'b1;
            state          <= IDLE;
          end else if (b_cnt == TMO_LAST) begin
            bready_o       <= 1'b0;
            done_o         <= 1'b1;
            done_resp_o    <= RESP_TMO;
            done_timeout_o <= 1'b1;
            cmd_ready_o    <= 1'b1;
            state          <= IDLE;
          end else begin
            b_cnt <= b_cnt + 16'd1;
          end
        end
        default: begin
          awvalid_o   <= 1'b0;
          wvalid_o    <= 1'b0;
          bready_o    <= 1'b0;
          cmd_ready_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_axi_wr_master.sv
// Bench for m_axi_wr_master: directed plan cases plus randomized transactions,
// each checked cycle-by-cycle against a timing model computed from slave delays.
module tb_m_axi_wr_master;
  localparam int AW = 32, DW = 32, IW = 4, SW = DW / 8, T = 16;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [IW-1:0] cmd_id_i = '0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_data_i = '0;
  logic [SW-1:0] cmd_strb_i = '0;
  logic [IW-1:0] awid_o;
  logic [AW-1:0] awaddr_o;
  logic          awvalid_o;
  logic          awready_i = 1'b0;
  logic [DW-1:0] wdata_o;
  logic [SW-1:0] wstrb_o;
  logic          wvalid_o;
  logic          wready_i = 1'b0;
  logic [IW-1:0] bid_i = '0;
  logic [1:0]    bresp_i = '0;
  logic          bvalid_i = 1'b0;
  logic          bready_o;
  logic          done_o;
  logic [1:0]    done_resp_o;
  logic          done_timeout_o;

  m_axi_wr_master #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TIMEOUT(T)) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_id_i(cmd_id_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .done_o(done_o), .done_resp_o(done_resp_o), .done_timeout_o(done_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } cmd_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.id   = IW'($urandom);
    c.addr = AW'($urandom);
    c.data = DW'($urandom);
    c.strb = SW'($urandom);
    return c;
  endfunction

  // Start at a negedge with the block idle. awd/wd: cycles the slave stalls
  // each channel; bd: WAIT_B cycles before bvalid (>= T means never).
  task automatic run_txn(input cmd_t c, input int awd, input int wd, input int bd,
                         input logic [IW-1:0] bid, input logic [1:0] bresp, input bit hold);
    int s, bmin, dn;
    logic [1:0] er;
    logic et;
    s    = 1 + ((awd > wd) ? awd : wd);   // cycle of the last AW/W handshake
    bmin = (bd < T - 1) ? bd : T - 1;
    dn   = s + 2 + bmin;                  // done cycle, counted from acceptance
    if (bd < T) begin
      er = (bid == c.id) ? bresp : 2'b10;
      et = 1'b0;
    end else begin
      er = 2'b11;
      et = 1'b1;
    end
    cmd_valid_i = 1'b1;
    cmd_id_i = c.id; cmd_addr_i = c.addr; cmd_data_i = c.data; cmd_strb_i = c.strb;
    chk("cmd_ready_idle", 64'(cmd_ready_o), 64'(1));
    @(posedge clk);
    for (int n = 1; n <= dn; n++) begin
      @(negedge clk);
      cmd_valid_i = hold;
      awready_i = (n >= 1 + awd);
      wready_i  = (n >= 1 + wd);
      bvalid_i  = (bd < T) && (n == s + 1 + bd);
      bid_i = bid; bresp_i = bresp;
      chk("awvalid", 64'(awvalid_o), 64'(n <= 1 + awd));
      chk("wvalid", 64'(wvalid_o), 64'(n <= 1 + wd));
      chk("bready", 64'(bready_o), 64'(n >= s + 1 && n <= s + 1 + bmin));
      chk("done", 64'(done_o), 64'(n == dn));
      chk("cmd_ready", 64'(cmd_ready_o), 64'(n == dn));
      if (n <= 1 + awd) begin
        chk("awid", 64'(awid_o), 64'(c.id));
        chk("awaddr", 64'(awaddr_o), 64'(c.addr));
      end
      if (n <= 1 + wd) begin
        chk("wdata", 64'(wdata_o), 64'(c.data));
        chk("wstrb", 64'(wstrb_o), 64'(c.strb));
      end
      if (n == dn) begin
        chk("done_resp", 64'(done_resp_o), 64'(er));
        chk("done_timeout", 64'(done_timeout_o), 64'(et));
        chk("awaddr_kept", 64'(awaddr_o), 64'(c.addr));
        chk("wdata_kept", 64'(wdata_o), 64'(c.data));
      end
    end
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      chk("idle_ready", 64'(cmd_ready_o), 64'(1));
      chk("idle_done", 64'(done_o), 64'(0));
    end
  endtask

  initial begin
    cmd_t c;
    int awd, wd, bd;
    logic [IW-1:0] bid;
    bit hold;

    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
    chk("rst_awvalid", 64'(awvalid_o), 64'(0));
    chk("rst_wvalid", 64'(wvalid_o), 64'(0));
    chk("rst_bready", 64'(bready_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_payload", 64'({awid_o, awaddr_o} | 64'(wdata_o) | 64'(wstrb_o)), 64'(0));
    chk("rst_resp", 64'({done_resp_o, done_timeout_o}), 64'(0));
    repeat (2) @(negedge clk);
    areset = 1'b1;
    #1 chk("rel_ready_before_edge", 64'(cmd_ready_o), 64'(0));
    @(posedge clk);
    #1 chk("rel_ready_after_edge", 64'(cmd_ready_o), 64'(1));
    @(negedge clk);

    // Basic write, best-case latency
    c.id = 4'h0; c.addr = 32'h1; c.data = 32'hABCDEFAC; c.strb = 4'b1010;
    run_txn(c, 0, 0, 0, 4'h0, 2'b00, 1'b0);
    idle(2);
    // W before AW
    c.data = 32'hEFDBCA54; c.addr = 32'h40;
    run_txn(c, 4, 0, 0, 4'h0, 2'b00, 1'b0);
    // AW before W
    run_txn(rand_cmd(), 0, 3, 1, 4'h0, 2'b00, 1'b0);
    // Error responses
    c.id = 4'h7;
    run_txn(c, 0, 0, 2, 4'h7, 2'b10, 1'b0);
    c.id = 4'h3;
    run_txn(c, 1, 1, 0, 4'h5, 2'b00, 1'b0);
    idle(1);
    // Timeout, then a normal command
    run_txn(rand_cmd(), 0, 0, 100, 4'h0, 2'b00, 1'b0);
    c.id = 4'h2;
    run_txn(c, 0, 0, 0, 4'h2, 2'b00, 1'b0);
    // B arrives on the timeout cycle (handshake wins), and one before it
    c.id = 4'h9;
    run_txn(c, 0, 0, T - 1, 4'h9, 2'b01, 1'b0);
    run_txn(c, 2, 1, T - 2, 4'h9, 2'b00, 1'b0);
    // Back-to-back with cmd_valid held high
    for (int i = 0; i < 3; i++) begin
      c = rand_cmd();
      run_txn(c, i, 0, i, c.id, 2'b00, i != 2);
    end
    idle(1);

    // Reset during SEND with AW stalled
    c = rand_cmd();
    cmd_valid_i = 1'b1;
    cmd_id_i = c.id; cmd_addr_i = c.addr; cmd_data_i = c.data; cmd_strb_i = c.strb;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("pre_rst_awvalid", 64'(awvalid_o), 64'(1));
    #2 areset = 1'b0;
    #1;
    chk("mid_rst_awvalid", 64'(awvalid_o), 64'(0));
    chk("mid_rst_wvalid", 64'(wvalid_o), 64'(0));
    chk("mid_rst_bready", 64'(bready_o), 64'(0));
    chk("mid_rst_ready", 64'(cmd_ready_o), 64'(0));
    repeat (2) @(negedge clk);
    chk("mid_rst_done", 64'(done_o), 64'(0));
    areset = 1'b1;
    #1 chk("mid_rel_ready_before", 64'(cmd_ready_o), 64'(0));
    @(posedge clk);
    #1 chk("mid_rel_ready_after", 64'(cmd_ready_o), 64'(1));
    chk("mid_rel_done", 64'(done_o), 64'(0));
    @(negedge clk);
    chk("mid_rel_done2", 64'(done_o), 64'(0));
    run_txn(rand_cmd(), 0, 0, 0, 4'h0, 2'b00, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      c    = rand_cmd();
      awd  = $urandom_range(0, 5);
      wd   = $urandom_range(0, 5);
      case ($urandom_range(0, 9))
        0:       bd = T + 5;
        1:       bd = T - 1;
        default: bd = $urandom_range(0, 6);
      endcase
      bid  = ($urandom_range(0, 3) == 0) ? IW'($urandom) : c.id;
      hold = (i != 59) && ($urandom_range(0, 1) == 1);
      run_txn(c, awd, wd, bd, bid, 2'($urandom), hold);
      if (!hold) idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
